// File: rtl/heater_ramp_ctrl.sv
// Staged-enable controller for a heater array: ramps the enabled channel count, applies a common
// PWM duty, tracks channel errors and trips every channel off at an error-count threshold.
module heater_ramp_ctrl #(
  parameter int N         = 32,
  parameter int RAMP_DIV  = 1024,
  parameter int PWM_W     = 8,
  parameter int ERR_CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(N+1)-1:0]   target,
  input  logic [PWM_W-1:0]         duty,
  input  logic [N-1:0]             heater_error,
  input  logic                     err_clear,
  input  logic [ERR_CNT_W-1:0]     trip_thresh,
  output logic [N-1:0]             heater_enable,
  output logic [$clog2(N+1)-1:0]   active_cnt,
  output logic [N-1:0]             err_sticky,
  output logic [ERR_CNT_W-1:0]     err_count,
  output logic                     tripped,
  output logic                     ramping
);

  localparam int CW   = $clog2(N + 1);
  localparam int RC_W = $clog2(RAMP_DIV);

  localparam logic [CW-1:0]        N_C       = CW'(N);
  localparam logic [CW-1:0]        ACT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [RC_W-1:0]      RAMP_LAST = RC_W'(RAMP_DIV - 1);
  localparam logic [RC_W-1:0]      RC_ONE    = {{(RC_W-1){1'b0}}, 1'b1};
  localparam logic [PWM_W-1:0]     PWM_ONE   = {{(PWM_W-1){1'b0}}, 1'b1};
  localparam logic [PWM_W-1:0]     PWM_FULL  = {PWM_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] CNT_ONE   = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_W-1:0] CNT_MAX   = {ERR_CNT_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_RAMP_DOWN = 3'd2,
    ST_HOLD      = 3'd3,
    ST_TRIP      = 3'd4
  } state_t;

  // Thermometer mask selecting channels 0 .. cnt-1
  function automatic logic [N-1:0] low_mask(input logic [CW-1:0] cnt);
    return ~({N{1'b1}} << cnt);
  endfunction

  state_t           state_r, nxt_state_s;
  logic [CW-1:0]    target_q_r, nxt_active_s;
  logic [RC_W-1:0]  ramp_cnt_r, nxt_ramp_cnt_s;
  logic [PWM_W-1:0] pwm_cnt_r;
  logic [N-1:0]     err_q_r, act_mask_s, masked_err_s, rising_s;
  logic             pwm_on_s;

  assign act_mask_s   = low_mask(active_cnt);
  assign pwm_on_s     = (pwm_cnt_r < duty) | (duty == PWM_FULL);
  assign masked_err_s = heater_error & act_mask_s;
  assign rising_s     = masked_err_s & ~err_q_r;

  // Ramp sequencing: next state, channel count and step timer
  always_comb begin
    nxt_state_s    = state_r;
    nxt_active_s   = active_cnt;
    nxt_ramp_cnt_s = ramp_cnt_r;
    case (state_r)
      ST_IDLE, ST_HOLD: begin
        nxt_ramp_cnt_s = '0;
        if (target_q_r > active_cnt) begin
          nxt_state_s = ST_RAMP_UP;
        end else if (target_q_r < active_cnt) begin
          nxt_state_s = ST_RAMP_DOWN;
        end else begin
          nxt_state_s = state_r;
        end
      end
      ST_RAMP_UP, ST_RAMP_DOWN: begin
        if (ramp_cnt_r == RAMP_LAST) begin
          nxt_ramp_cnt_s = '0;
          // Step toward the current target, so a reversal takes effect at this boundary
          if (target_q_r > active_cnt) begin
            nxt_active_s = active_cnt + ACT_ONE;
          end else if (target_q_r < active_cnt) begin
            nxt_active_s = active_cnt - ACT_ONE;
          end else begin
            nxt_active_s = active_cnt;
          end
          if (nxt_active_s == target_q_r) begin
            nxt_state_s = (nxt_active_s == '0) ? ST_IDLE : ST_HOLD;
          end else if (nxt_active_s < target_q_r) begin
            nxt_state_s = ST_RAMP_UP;
          end else begin
            nxt_state_s = ST_RAMP_DOWN;
          end
        end else begin
          nxt_ramp_cnt_s = ramp_cnt_r + RC_ONE;
        end
      end
      ST_TRIP: begin
        nxt_active_s   = '0;
        nxt_ramp_cnt_s = '0;
        if (err_clear) begin
          nxt_state_s = ST_IDLE;
        end else begin
          nxt_state_s = ST_TRIP;
        end
      end
      default: begin
        nxt_state_s    = ST_IDLE;
        nxt_active_s   = '0;
        nxt_ramp_cnt_s = '0;
      end
    endcase
    if ((state_r != ST_TRIP) && tripped && !err_clear) begin
      nxt_state_s    = ST_TRIP;
      nxt_active_s   = '0;
      nxt_ramp_cnt_s = '0;
    end else begin
      nxt_state_s = nxt_state_s;
    end
  end

  // FSM state and registered ramp outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      active_cnt <= '0;
      ramp_cnt_r <= '0;
      ramping    <= 1'b0;
    end else begin
      state_r    <= nxt_state_s;
      active_cnt <= nxt_active_s;
      ramp_cnt_r <= nxt_ramp_cnt_s;
      ramping    <= (nxt_state_s == ST_RAMP_UP) || (nxt_state_s == ST_RAMP_DOWN);
    end
  end

  // Clamped target and free-running PWM phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q_r <= '0;
      pwm_cnt_r  <= '0;
    end else begin
      target_q_r <= (target > N_C) ? N_C : target;
      pwm_cnt_r  <= pwm_cnt_r + PWM_ONE;
    end
  end

  // Per-channel enables, all channels share one PWM phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      heater_enable <= '0;
    end else begin
      heater_enable <= act_mask_s & {N{pwm_on_s}} & {N{~tripped}};
    end
  end

  // Error edge detection, sticky flags, saturating count and trip latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q_r    <= '0;
      err_sticky <= '0;
      err_count  <= '0;
      tripped    <= 1'b0;
    end else begin
      err_q_r <= masked_err_s;
      if (err_clear) begin
        err_sticky <= '0;
        err_count  <= '0;
        tripped    <= 1'b0;
      end else begin
        err_sticky <= err_sticky | masked_err_s;
        if ((|rising_s) && (err_count != CNT_MAX)) begin
          err_count <= err_count + CNT_ONE;
        end else begin
          err_count <= err_count;
        end
        if ((trip_thresh != '0) && (err_count >= trip_thresh)) begin
          tripped <= 1'b1;
        end else begin
          tripped <= tripped;
        end
      end
    end
  end

endmodule

// File: tb/tb_heater_ramp_ctrl.sv
// Self-checking bench for heater_ramp_ctrl: ramp timing, clamp, PWM duty, trip, masking, clear, reset.
module tb_heater_ramp_ctrl;

  logic        clk;
  logic        rst_n;
  logic [5:0]  target;
  logic [7:0]  duty;
  logic [31:0] heater_error;
  logic        err_clear;
  logic [15:0] trip_thresh;
  logic [31:0] heater_enable;
  logic [5:0]  active_cnt;
  logic [31:0] err_sticky;
  logic [15:0] err_count;
  logic        tripped;
  logic        ramping;

  int errors = 0;
  int checks = 0;

  heater_ramp_ctrl #(.N(32), .RAMP_DIV(8), .PWM_W(8), .ERR_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .target(target), .duty(duty), .heater_error(heater_error),
    .err_clear(err_clear), .trip_thresh(trip_thresh), .heater_enable(heater_enable),
    .active_cnt(active_cnt), .err_sticky(err_sticky), .err_count(err_count),
    .tripped(tripped), .ramping(ramping)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Set target and check every cycle against the ideal staircase: count reaches its new
  // value every 8 cycles starting 10 cycles after the request; enables trail by one cycle.
  task automatic run_ramp(input int from, input int to);
    int eff, steps, dir, ka, ke, ea, ee;
    logic [31:0] exp_en;
    logic exp_rp;
    eff   = (to > 32) ? 32 : to;
    steps = (eff > from) ? eff - from : from - eff;
    dir   = (eff >= from) ? 1 : -1;
    target = 6'(to);
    for (int j = 1; j <= 8 * steps + 6; j++) begin
      tick();
      ka = (j < 2) ? 0 : (j - 2) / 8;
      if (ka > steps) ka = steps;
      ke = (j < 3) ? 0 : (j - 3) / 8;
      if (ke > steps) ke = steps;
      ea = from + dir * ka;
      ee = from + dir * ke;
      exp_en = 32'h0;
      for (int i = 0; i < ee; i++) exp_en[i] = 1'b1;
      exp_rp = (steps > 0) && (j >= 2) && (j <= 8 * steps + 1);
      checks += 3;
      if (active_cnt !== 6'(ea)) begin
        errors++;
        $display("FAIL ramp_active %0d->%0d j=%0d got=%0d exp=%0d", from, to, j, active_cnt, ea);
      end
      if (heater_enable !== exp_en) begin
        errors++;
        $display("FAIL ramp_enable %0d->%0d j=%0d got=%h exp=%h", from, to, j, heater_enable, exp_en);
      end
      if (ramping !== exp_rp) begin
        errors++;
        $display("FAIL ramp_flag %0d->%0d j=%0d got=%b exp=%b", from, to, j, ramping, exp_rp);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; target = 6'd0; duty = 8'hFF; heater_error = 32'h0;
    err_clear = 1'b0; trip_thresh = 16'd0;
    repeat (3) tick();
    checks += 6;
    if (heater_enable !== 32'h0) begin errors++; $display("FAIL reset_enable got=%h exp=0", heater_enable); end
    if (active_cnt !== 6'd0) begin errors++; $display("FAIL reset_active got=%0d exp=0", active_cnt); end
    if (err_sticky !== 32'h0) begin errors++; $display("FAIL reset_sticky got=%h exp=0", err_sticky); end
    if (err_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", err_count); end
    if (tripped !== 1'b0) begin errors++; $display("FAIL reset_tripped got=%b exp=0", tripped); end
    if (ramping !== 1'b0) begin errors++; $display("FAIL reset_ramping got=%b exp=0", ramping); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ramp_up();
    run_ramp(0, 4);
  endtask

  task automatic test_ramp_down();
    run_ramp(4, 1);
    run_ramp(1, 0);
  endtask

  task automatic test_clamp();
    run_ramp(0, 63);
    run_ramp(32, 4);
  endtask

  task automatic test_pwm();
    int cnt [4];
    int bad_phase, upper;
    logic [7:0] dv;
    for (int pass = 0; pass < 3; pass++) begin
      dv = (pass == 0) ? 8'd64 : (pass == 1) ? 8'($urandom_range(1, 254)) : 8'd0;
      duty = dv;
      repeat (3) tick();
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      bad_phase = 0; upper = 0;
      for (int c = 0; c < 256; c++) begin
        tick();
        for (int i = 0; i < 4; i++) if (heater_enable[i]) cnt[i]++;
        if (heater_enable[3:0] != 4'h0 && heater_enable[3:0] != 4'hF) bad_phase++;
        if (heater_enable[31:4] != 28'h0) upper++;
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (cnt[i] != int'(dv)) begin
          errors++;
          $display("FAIL pwm_ontime ch%0d duty=%0d got=%0d exp=%0d", i, dv, cnt[i], dv);
        end
      end
      checks += 2;
      if (bad_phase != 0) begin errors++; $display("FAIL pwm_phase duty=%0d got=%0d exp=0", dv, bad_phase); end
      if (upper != 0) begin errors++; $display("FAIL pwm_upper duty=%0d got=%0d exp=0", dv, upper); end
    end
    duty = 8'hFF;
    repeat (3) tick();
    checks++;
    if (heater_enable !== 32'hF) begin errors++; $display("FAIL pwm_full got=%h exp=0000000f", heater_enable); end
  endtask

  task automatic test_trip();
    int thr, ch;
    thr = $urandom_range(2, 5);
    ch  = $urandom_range(0, 3);
    trip_thresh = 16'(thr);
    for (int k = 0; k < thr; k++) begin
      heater_error = 32'h1 << ch;
      tick();
      heater_error = 32'h0;
      checks += 2;
      if (err_count !== 16'(k + 1)) begin
        errors++; $display("FAIL trip_count k=%0d got=%0d exp=%0d", k, err_count, k + 1);
      end
      if (tripped !== 1'b0) begin errors++; $display("FAIL trip_early k=%0d got=%b exp=0", k, tripped); end
      if (k < thr - 1) repeat ($urandom_range(1, 3)) tick();
    end
    tick();
    checks += 3;
    if (tripped !== 1'b1) begin errors++; $display("FAIL trip_set got=%b exp=1", tripped); end
    if (heater_enable !== 32'hF) begin errors++; $display("FAIL trip_enable_lag got=%h exp=f", heater_enable); end
    if (err_sticky !== (32'h1 << ch)) begin
      errors++; $display("FAIL trip_sticky got=%h exp=%h", err_sticky, 32'h1 << ch);
    end
    tick();
    checks += 2;
    if (heater_enable !== 32'h0) begin errors++; $display("FAIL trip_enable_off got=%h exp=0", heater_enable); end
    if (active_cnt !== 6'd0) begin errors++; $display("FAIL trip_active got=%0d exp=0", active_cnt); end
    repeat (5) tick();
    checks += 2;
    if (tripped !== 1'b1) begin errors++; $display("FAIL trip_hold got=%b exp=1", tripped); end
    if (heater_enable !== 32'h0) begin errors++; $display("FAIL trip_hold_en got=%h exp=0", heater_enable); end
    target = 6'd0;
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    trip_thresh = 16'd0;
    checks += 3;
    if (err_count !== 16'd0) begin errors++; $display("FAIL clear_count got=%0d exp=0", err_count); end
    if (err_sticky !== 32'h0) begin errors++; $display("FAIL clear_sticky got=%h exp=0", err_sticky); end
    if (tripped !== 1'b0) begin errors++; $display("FAIL clear_tripped got=%b exp=0", tripped); end
    tick();
    run_ramp(0, 4);
  endtask

  task automatic test_mask_random();
    int m_cnt;
    logic [31:0] m_sticky, prev, m, stim;
    for (int r = 0; r < 2; r++) begin
      heater_error = 32'h1 << 10;
      repeat (3) tick();
      heater_error = 32'h0;
      tick();
    end
    checks += 2;
    if (err_count !== 16'd0) begin errors++; $display("FAIL mask_count got=%0d exp=0", err_count); end
    if (err_sticky !== 32'h0) begin errors++; $display("FAIL mask_sticky got=%h exp=0", err_sticky); end
    heater_error = 32'h2;
    repeat (5) tick();
    checks += 2;
    if (err_count !== 16'd1) begin errors++; $display("FAIL held_count got=%0d exp=1", err_count); end
    if (err_sticky !== 32'h2) begin errors++; $display("FAIL held_sticky got=%h exp=2", err_sticky); end
    m_cnt = 1; m_sticky = 32'h2; prev = 32'h2;
    for (int c = 0; c < 100; c++) begin
      stim = $urandom() & $urandom();
      heater_error = stim;
      tick();
      m = stim & 32'hF;
      if ((m & ~prev) != 32'h0 && m_cnt < 65535) m_cnt++;
      m_sticky |= m;
      prev = m;
      checks += 2;
      if (err_count !== 16'(m_cnt)) begin
        errors++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, err_count, m_cnt);
      end
      if (err_sticky !== m_sticky) begin
        errors++; $display("FAIL rand_sticky c=%0d got=%h exp=%h", c, err_sticky, m_sticky);
      end
    end
    heater_error = 32'h0;
    tick();
    checks++;
    if (tripped !== 1'b0) begin errors++; $display("FAIL thresh0_tripped got=%b exp=0", tripped); end
  endtask

  task automatic test_clear_edge();
    heater_error = 32'h0;
    tick();
    heater_error = 32'h1;
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    checks += 2;
    if (err_count !== 16'd0) begin errors++; $display("FAIL clredge_count got=%0d exp=0", err_count); end
    if (err_sticky !== 32'h0) begin errors++; $display("FAIL clredge_sticky got=%h exp=0", err_sticky); end
    tick();
    checks += 2;
    if (err_count !== 16'd0) begin errors++; $display("FAIL clredge_noedge got=%0d exp=0", err_count); end
    if (err_sticky !== 32'h1) begin errors++; $display("FAIL clredge_level got=%h exp=1", err_sticky); end
    heater_error = 32'h0;
    tick();
  endtask

  task automatic test_reset_midramp();
    target = 6'd8;
    repeat (13) tick();
    checks += 2;
    if (active_cnt !== 6'd5) begin errors++; $display("FAIL mid_active got=%0d exp=5", active_cnt); end
    if (ramping !== 1'b1) begin errors++; $display("FAIL mid_ramping got=%b exp=1", ramping); end
    #3;
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (heater_enable !== 32'h0) begin errors++; $display("FAIL async_enable got=%h exp=0", heater_enable); end
    if (active_cnt !== 6'd0) begin errors++; $display("FAIL async_active got=%0d exp=0", active_cnt); end
    if (err_sticky !== 32'h0) begin errors++; $display("FAIL async_sticky got=%h exp=0", err_sticky); end
    if (ramping !== 1'b0) begin errors++; $display("FAIL async_ramping got=%b exp=0", ramping); end
    if (tripped !== 1'b0) begin errors++; $display("FAIL async_tripped got=%b exp=0", tripped); end
    repeat (2) tick();
    rst_n = 1'b1;
    run_ramp(0, 3);
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_clamp();
    test_pwm();
    test_trip();
    test_mask_random();
    test_clear_edge();
    test_reset_midramp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
